// File: rtl/conv_of_collector_if.sv
// Stream bundle between the systolic array, the output collector and its consumer.
// master = collector side, slave = array/consumer environment side.
interface conv_of_collector_if #(
   parameter int K_NUM       = 3,
   parameter int OF_BITWIDTH = 16,
   parameter int ADDR_W      = 14
);
   logic [K_NUM*OF_BITWIDTH-1:0] of_i_data;
   logic [K_NUM-1:0]             of_i_valid;
   logic [K_NUM*OF_BITWIDTH-1:0] o_data;
   logic                         o_valid;
   logic                         o_ready;
   logic [ADDR_W-1:0]            o_addr;
   logic                         o_last;

   modport master (
      input  of_i_data, of_i_valid, o_ready,
      output o_data, o_valid, o_addr, o_last
   );

   modport slave (
      output of_i_data, of_i_valid, o_ready,
      input  o_data, o_valid, o_addr, o_last
   );
endinterface

// File: rtl/conv_of_collector.sv
// Deskews the skewed array columns into aligned per-pixel vectors, applies optional
// ReLU and streams them out of a small FIFO with raster address, last and frame-done.
module conv_of_collector #(
   parameter int K_NUM       = 3,
   parameter int OF_BITWIDTH = 16,
   parameter int OF_WIDTH    = 128,
   parameter int OF_HEIGHT   = 128,
   parameter int FIFO_DEPTH  = 16,
   parameter int RELU_EN     = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          of_start,
   conv_of_collector_if.master           strm,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          err_overflow,
   output logic                          err_skew
);
   localparam int ADDR_W = $clog2(OF_WIDTH*OF_HEIGHT);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int VEC_W  = K_NUM*OF_BITWIDTH;
   localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OF_WIDTH*OF_HEIGHT-1);

   function automatic logic [OF_BITWIDTH-1:0] relu(input logic [OF_BITWIDTH-1:0] v);
      if ((RELU_EN != 0) && v[OF_BITWIDTH-1]) begin
         return '0;
      end else begin
         return v;
      end
   endfunction

   logic [K_NUM-1:0][OF_BITWIDTH-1:0] tap_data_s;
   logic [K_NUM-1:0]                  tap_vld_s;

   // Lane k is delayed K_NUM-1-k cycles so every lane lines up with the last column.
   for (genvar k = 0; k < K_NUM; k++) begin : g_lane
      localparam int DLY = K_NUM - 1 - k;
      if (DLY == 0) begin : g_direct
         assign tap_data_s[k] = strm.of_i_data[k*OF_BITWIDTH +: OF_BITWIDTH];
         assign tap_vld_s[k]  = strm.of_i_valid[k];
      end else begin : g_delay
         logic [DLY-1:0][OF_BITWIDTH-1:0] dly_data_r;
         logic [DLY-1:0]                  dly_vld_r;
         // shift register delay line for data and valid
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dly_data_r <= '0;
               dly_vld_r  <= '0;
            end else if (of_start) begin
               dly_data_r <= '0;
               dly_vld_r  <= '0;
            end else begin
               dly_data_r[0] <= strm.of_i_data[k*OF_BITWIDTH +: OF_BITWIDTH];
               dly_vld_r[0]  <= strm.of_i_valid[k];
               for (int j = 1; j < DLY; j++) begin
                  dly_data_r[j] <= dly_data_r[j-1];
                  dly_vld_r[j]  <= dly_vld_r[j-1];
               end
            end
         end
         assign tap_data_s[k] = dly_data_r[DLY-1];
         assign tap_vld_s[k]  = dly_vld_r[DLY-1];
      end
   end

   logic [K_NUM-1:0][OF_BITWIDTH-1:0] align_data_r;
   logic [K_NUM-1:0]                  align_vld_r;

   // align register captures the deskewed lanes after ReLU
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         align_data_r <= '0;
         align_vld_r  <= '0;
      end else if (of_start) begin
         align_data_r <= '0;
         align_vld_r  <= '0;
      end else begin
         for (int k = 0; k < K_NUM; k++) begin
            align_data_r[k] <= relu(tap_data_s[k]);
         end
         align_vld_r <= tap_vld_s;
      end
   end

   logic [VEC_W-1:0]  mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_idx_r, rd_idx_r, rd_nxt_s;
   logic [LVL_W-1:0]  level_r, level_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [VEC_W-1:0]  head_r, head_nxt_s;
   logic              valid_r, last_r, frame_done_r, err_ovf_r, err_skew_r;
   logic              push_s, skew_s, pop_s, full_s, wr_en_s, ovf_s;

   assign push_s  = &align_vld_r;
   assign skew_s  = (|align_vld_r) & ~(&align_vld_r);
   assign pop_s   = valid_r & strm.o_ready;
   assign full_s  = (level_r == FULL_LVL);
   assign wr_en_s = push_s & (~full_s | pop_s);
   assign ovf_s   = push_s & full_s & ~pop_s;

   // next occupancy, read pointer, address and head-of-queue (with write bypass when draining to empty)
   always_comb begin
      level_nxt_s = level_r;
      rd_nxt_s    = rd_idx_r;
      addr_nxt_s  = addr_r;
      head_nxt_s  = '0;
      case ({wr_en_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_W'(1);
         2'b01:   level_nxt_s = level_r - LVL_W'(1);
         default: level_nxt_s = level_r;
      endcase
      if (pop_s) begin
         rd_nxt_s   = rd_idx_r + PTR_W'(1);
         addr_nxt_s = (addr_r == LAST_ADDR) ? '0 : addr_r + ADDR_W'(1);
      end else begin
         rd_nxt_s   = rd_idx_r;
         addr_nxt_s = addr_r;
      end
      if (level_nxt_s == '0) begin
         head_nxt_s = '0;
      end else if (wr_en_s && ((level_r - LVL_W'(pop_s)) == '0)) begin
         head_nxt_s = align_data_r;
      end else begin
         head_nxt_s = mem_r[rd_nxt_s];
      end
   end

   // FIFO storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en_s && !of_start) begin
         mem_r[wr_idx_r] <= align_data_r;
      end
   end

   // FIFO control, output registers, address counter and sticky error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_idx_r     <= '0;
         rd_idx_r     <= '0;
         level_r      <= '0;
         addr_r       <= '0;
         head_r       <= '0;
         valid_r      <= 1'b0;
         last_r       <= 1'b0;
         frame_done_r <= 1'b0;
         err_ovf_r    <= 1'b0;
         err_skew_r   <= 1'b0;
      end else if (of_start) begin
         wr_idx_r     <= '0;
         rd_idx_r     <= '0;
         level_r      <= '0;
         addr_r       <= '0;
         head_r       <= '0;
         valid_r      <= 1'b0;
         last_r       <= 1'b0;
         frame_done_r <= 1'b0;
         err_ovf_r    <= 1'b0;
         err_skew_r   <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_idx_r <= wr_idx_r + PTR_W'(1);
         end
         rd_idx_r     <= rd_nxt_s;
         level_r      <= level_nxt_s;
         addr_r       <= addr_nxt_s;
         head_r       <= head_nxt_s;
         valid_r      <= (level_nxt_s != '0);
         last_r       <= (addr_nxt_s == LAST_ADDR);
         frame_done_r <= pop_s & last_r;
         err_ovf_r    <= err_ovf_r | ovf_s;
         err_skew_r   <= err_skew_r | skew_s;
      end
   end

   assign strm.o_data  = head_r;
   assign strm.o_valid = valid_r;
   assign strm.o_addr  = addr_r;
   assign strm.o_last  = last_r;
   assign frame_done   = frame_done_r;
   assign fifo_level   = level_r;
   assign err_overflow = err_ovf_r;
   assign err_skew     = err_skew_r;
endmodule

// File: tb/tb_conv_of_collector.sv
// Randomized bench for conv_of_collector against a cycle-level queue model of the
// column skew, FIFO, address counter and error flags.
module tb_conv_of_collector;
   localparam int K  = 3;
   localparam int B  = 16;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int D  = 4;
   localparam int N  = W*H;
   localparam int AW = 4;
   localparam int LW = 3;
   localparam int R  = 16;

   logic clk = 1'b0;
   logic rst;
   logic of_start;
   logic frame_done;
   logic [LW-1:0] fifo_level;
   logic err_overflow, err_skew;

   always #5 clk = ~clk;

   conv_of_collector_if #(.K_NUM(K), .OF_BITWIDTH(B), .ADDR_W(AW)) bus ();

   conv_of_collector #(
      .K_NUM(K), .OF_BITWIDTH(B), .OF_WIDTH(W), .OF_HEIGHT(H),
      .FIFO_DEPTH(D), .RELU_EN(1)
   ) dut (
      .clk(clk), .rst(rst), .of_start(of_start), .strm(bus),
      .frame_done(frame_done), .fifo_level(fifo_level),
      .err_overflow(err_overflow), .err_skew(err_skew)
   );

   // reference model state
   logic [K*B-1:0] mq[$];
   int             m_addr;
   bit             m_fd, m_ovf, m_skew;
   logic [B-1:0]   hist_d [R][K];
   bit             hist_v [R][K];
   logic [B-1:0]   fut_d  [R][K];
   bit             fut_v  [R][K];
   int             n;
   int             checks;
   int             errors;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic logic [B-1:0] relu_m(input logic [B-1:0] v);
      return v[B-1] ? '0 : v;
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < R; i++) begin
         for (int k = 0; k < K; k++) begin
            hist_v[i][k] = 1'b0;
            hist_d[i][k] = '0;
         end
      end
   endtask

   task automatic clear_model();
      mq.delete();
      m_addr = 0;
      m_fd   = 1'b0;
      m_ovf  = 1'b0;
      m_skew = 1'b0;
      clear_hist();
   endtask

   task automatic compare_outputs();
      bit exp_valid;
      exp_valid = (mq.size() > 0);
      check("o_valid", 64'(bus.o_valid), 64'(exp_valid));
      check("o_data", 64'(bus.o_data), exp_valid ? 64'(mq[0]) : 64'd0);
      check("o_addr", 64'(bus.o_addr), 64'(m_addr));
      check("o_last", 64'(bus.o_last), 64'(m_addr == N-1));
      check("frame_done", 64'(frame_done), 64'(m_fd));
      check("fifo_level", 64'(fifo_level), 64'(mq.size()));
      check("err_overflow", 64'(err_overflow), 64'(m_ovf));
      check("err_skew", 64'(err_skew), 64'(m_skew));
   endtask

   // The vector seen by the FIFO in cycle n is column k as driven in cycle n-K+k.
   task automatic model_edge(input bit start, input bit ready);
      bit all_v, any_v, pop, full;
      logic [K*B-1:0] vec;
      if (start) begin
         clear_model();
         return;
      end
      all_v = 1'b1;
      any_v = 1'b0;
      vec   = '0;
      for (int k = 0; k < K; k++) begin
         int idx;
         idx = (n - K + k) % R;
         all_v = all_v & hist_v[idx][k];
         any_v = any_v | hist_v[idx][k];
         vec[k*B +: B] = relu_m(hist_d[idx][k]);
      end
      pop  = (mq.size() > 0) && ready;
      full = (mq.size() == D);
      m_fd = pop && (m_addr == N-1);
      if (pop) begin
         void'(mq.pop_front());
         m_addr = (m_addr + 1) % N;
      end
      if (all_v) begin
         if (full && !pop) m_ovf = 1'b1;
         else mq.push_back(vec);
      end else if (any_v) begin
         m_skew = 1'b1;
      end
   endtask

   task automatic sched_col(input int dly, input int k, input logic [B-1:0] v);
      fut_v[(n+dly)%R][k] = 1'b1;
      fut_d[(n+dly)%R][k] = v;
   endtask

   task automatic sched_rand();
      for (int k = 0; k < K; k++) sched_col(k, k, B'($urandom));
   endtask

   task automatic step(input bit start, input bit ready);
      of_start    = start;
      bus.o_ready = ready;
      for (int k = 0; k < K; k++) begin
         bus.of_i_data[k*B +: B] = fut_d[n%R][k];
         bus.of_i_valid[k]       = fut_v[n%R][k];
         hist_d[n%R][k]          = fut_d[n%R][k];
         hist_v[n%R][k]          = fut_v[n%R][k];
         fut_v[n%R][k]           = 1'b0;
      end
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_edge(start, ready);
      #1;
      n++;
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      of_start       = 1'b0;
      bus.o_ready    = 1'b0;
      bus.of_i_valid = '0;
      bus.of_i_data  = '0;
      for (int i = 0; i < R; i++) begin
         for (int k = 0; k < K; k++) fut_v[i][k] = 1'b0;
      end
      clear_model();
      #2;
      compare_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      n      = R;
      for (int i = 0; i < R; i++) begin
         for (int k = 0; k < K; k++) fut_d[i][k] = '0;
      end
      do_reset();

      // basic alignment with a negative top channel
      step(1'b1, 1'b1);
      sched_col(0, 0, 16'h0100);
      sched_col(1, 1, 16'h0200);
      sched_col(2, 2, 16'hFF00);
      repeat (8) step(1'b0, 1'b1);

      // streaming frame, then the start of the next frame
      step(1'b1, 1'b1);
      for (int p = 0; p < N; p++) begin
         sched_rand();
         step(1'b0, 1'b1);
      end
      repeat (6) step(1'b0, 1'b1);
      for (int p = 0; p < 3; p++) begin
         sched_rand();
         step(1'b0, 1'b1);
      end
      repeat (6) step(1'b0, 1'b1);

      // backpressure and overflow
      step(1'b1, 1'b0);
      for (int p = 0; p < 6; p++) begin
         sched_rand();
         step(1'b0, 1'b0);
      end
      repeat (4) step(1'b0, 1'b0);
      repeat (8) step(1'b0, 1'b1);

      // full FIFO with a pop in the same cycle as a push
      step(1'b1, 1'b0);
      for (int p = 0; p < D; p++) begin
         sched_rand();
         step(1'b0, 1'b0);
      end
      repeat (3) step(1'b0, 1'b0);
      sched_rand();
      repeat (3) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      repeat (8) step(1'b0, 1'b1);

      // skew fault, cleared by of_start
      step(1'b1, 1'b1);
      sched_col(0, 0, B'($urandom));
      sched_col(3, 1, B'($urandom));
      sched_col(2, 2, B'($urandom));
      repeat (8) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      sched_rand();
      repeat (6) step(1'b0, 1'b1);

      // random traffic with random backpressure and rare restarts
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) != 0) sched_rand();
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
      end
      repeat (10) step(1'b0, 1'b1);

      // reset mid-frame with address 5 and three entries queued
      step(1'b1, 1'b1);
      for (int p = 0; p < 5; p++) begin
         sched_rand();
         step(1'b0, 1'b1);
      end
      repeat (5) step(1'b0, 1'b1);
      for (int p = 0; p < 3; p++) begin
         sched_rand();
         step(1'b0, 1'b0);
      end
      repeat (4) step(1'b0, 1'b0);
      check("pre_reset_addr", 64'(bus.o_addr), 64'd5);
      check("pre_reset_level", 64'(fifo_level), 64'd3);
      do_reset();
      sched_rand();
      repeat (6) step(1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
